// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    // One-hot grant vector for a binary requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage : arb_pkg

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping mod 8.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] cand;

    // Scan upward from ptr; the first hit wins, later hits are ignored.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule : rr_pick8

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner arbitration for a shared 8:1 mux with hold-limit preemption
// and a one-cycle turnaround so sel never moves under a live grant.
module mux8_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout
);

    // A zero-width counter is illegal, so the disabled case keeps one unused bit.
    localparam int unsigned HCNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));
    localparam logic              HOLD_EN   = (MAX_HOLD != 0);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HCNT_W-1:0] hold_q, hold_d;

    logic [SEL_W-1:0]  pick_idx;
    logic              pick_found;
    logic              release_c;
    logic              preempt_c;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // State and output registers; reset clears the grant without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    // Next-state and next-output logic; done only matters while an owner holds the mux.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        release_c = 1'b0;
        preempt_c = 1'b0;

        case (state_q)
            ARB_IDLE, ARB_RELEASE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (pick_found) begin
                    state_d = ARB_GRANT;
                    grant_d = onehot(pick_idx);
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    ptr_d   = pick_idx + SEL_W'(1);
                    hold_d  = '0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end

            ARB_GRANT: begin
                release_c = done || !req[sel_q];
                preempt_c = HOLD_EN && (hold_q == HOLD_LAST) && !release_c;
                if (release_c || preempt_c) begin
                    state_d   = ARB_RELEASE;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    timeout_d = preempt_c;
                end else if (HOLD_EN && (hold_q != '1)) begin
                    hold_d = hold_q + HCNT_W'(1);
                end
            end

            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule : mux8_rr_arbiter
